// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants used by the instruction memory slice.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RV32_NOP = 32'h00000013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } imem_load_state_t;

    // Registered fetch result presented to the IF/ID boundary.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
        logic            fault;
    } fetch_out_t;

    // Even parity bit: XOR of the word, so word plus bit has an even popcount.
    function automatic logic even_parity(input logic [XLEN-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_loader_fsm.sv
// Load-port sequencer for imem_sync_loadable: RUN/LOAD/DRAIN state, word
// counter, load handshake outputs and the write strobe into the array.
module imem_loader_fsm
    import rv32i_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start,
    input  logic [AW-1:0]   load_base,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic            loading,
    output logic            loading_nxt_c,
    output logic            wr_en_c,
    output logic [AW-1:0]   wr_idx_c,
    output logic [XLEN-1:0] wr_data_c
);

    imem_load_state_t state;
    imem_load_state_t state_nxt;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    cnt_nxt;
    logic             beat_c;

    // State, counter and the handshake flags, all registered from next-state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            load_ready <= 1'b0;
            loading    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            load_ready <= (state_nxt == LOAD);
            loading    <= (state_nxt != RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beat_c    = 1'b0;
        case (state)
            RUN: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = load_base;
                end
            end
            LOAD: begin
                beat_c = load_valid;
                if (beat_c) begin
                    // DEPTH is a power of two, so the natural AW-bit rollover is the wrap.
                    cnt_nxt = AW'(cnt + AW'(1));
                    if (load_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Write is combinational so a beat accepted just before an async reset still lands.
    assign wr_en_c       = beat_c;
    assign wr_idx_c      = cnt;
    assign wr_data_c     = load_data;
    assign loading_nxt_c = (state_nxt != RUN);

endmodule

// File: rtl/imem_sync_loadable.sv
// Synchronous RV32I instruction memory with registered fetch port and a
// streaming load port. Define IMEM_PARITY_EN to add per-word even parity.
module imem_sync_loadable
    import rv32i_pkg::*;
#(
    parameter  int unsigned     DEPTH     = 1024,
    parameter  logic [XLEN-1:0] NOP_INSTR = RV32_NOP,
    parameter  string           INIT_FILE = "",
    localparam int unsigned     AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic            fetch_fault,
    input  logic            load_start,
    input  logic [AW-1:0]   load_base,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic            loading
`ifdef IMEM_PARITY_EN
    ,
    output logic            parity_err
`endif
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = XLEN + 1;
`else
    localparam int unsigned MEM_W = XLEN;
`endif

    logic                  loading_nxt_c;
    logic                  wr_en_c;
    logic [AW-1:0]         wr_idx_c;
    logic [XLEN-1:0]       wr_data_c;
    logic [MEM_W-1:0]      wr_word_c;
    logic [MEM_W-1:0]      rd_word_c;
    logic [XLEN-1:0]       rd_instr_c;
    logic [AW-1:0]         fetch_idx_c;
    logic                  misaligned_c;
    logic                  out_of_range_c;
    logic                  fault_c;
    fetch_out_t            fo;
    fetch_out_t            fo_nxt;
    logic [MEM_W-1:0]      mem [DEPTH];

    imem_loader_fsm #(
        .DEPTH (DEPTH)
    ) u_loader (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .loading       (loading),
        .loading_nxt_c (loading_nxt_c),
        .wr_en_c       (wr_en_c),
        .wr_idx_c      (wr_idx_c),
        .wr_data_c     (wr_data_c)
    );

`ifdef IMEM_PARITY_EN
    assign wr_word_c = {even_parity(wr_data_c), wr_data_c};
`else
    assign wr_word_c = wr_data_c;
`endif

    // Storage is not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= wr_word_c;
        end
    end

    assign fetch_idx_c    = fetch_pc[AW+1:2];
    assign misaligned_c   = (fetch_pc[1:0] != 2'b00);
    assign out_of_range_c = ((fetch_pc >> (AW + 2)) != '0);
    assign fault_c        = misaligned_c || out_of_range_c;
    assign rd_word_c      = mem[fetch_idx_c];

`ifdef IMEM_PARITY_EN
    logic rd_bad_c;
    logic parity_err_nxt;

    assign rd_bad_c   = ^rd_word_c;
    assign rd_instr_c = rd_bad_c ? NOP_INSTR : rd_word_c[XLEN-1:0];

    always_comb begin
        parity_err_nxt = parity_err;
        if (flush || loading_nxt_c) begin
            parity_err_nxt = 1'b0;
        end else if (stall) begin
            parity_err_nxt = parity_err;
        end else if (!loading && fetch_en) begin
            parity_err_nxt = !fault_c && rd_bad_c;
        end else begin
            parity_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_nxt;
        end
    end
`else
    assign rd_instr_c = rd_word_c;
`endif

    // Output priority: flush / load in progress, then stall hold, then fetch, else idle NOP.
    always_comb begin
        fo_nxt = fo;
        if (flush || loading_nxt_c) begin
            fo_nxt.instr = NOP_INSTR;
            fo_nxt.valid = 1'b0;
            fo_nxt.fault = 1'b0;
        end else if (stall) begin
            fo_nxt = fo;
        end else if (!loading && fetch_en) begin
            fo_nxt.pc    = fetch_pc;
            fo_nxt.valid = 1'b1;
            fo_nxt.fault = fault_c;
            fo_nxt.instr = fault_c ? NOP_INSTR : rd_instr_c;
        end else begin
            fo_nxt.instr = NOP_INSTR;
            fo_nxt.valid = 1'b0;
            fo_nxt.fault = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fo.instr <= NOP_INSTR;
            fo.pc    <= '0;
            fo.valid <= 1'b0;
            fo.fault <= 1'b0;
        end else begin
            fo <= fo_nxt;
        end
    end

    assign instr       = fo.instr;
    assign instr_pc    = fo.pc;
    assign instr_valid = fo.valid;
    assign fetch_fault = fo.fault;

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Self-checking bench for imem_sync_loadable: spec-level reference model compared
// every cycle, plus literal expectations. Builds with or without IMEM_PARITY_EN.
`timescale 1ns/1ps
module tb_imem_sync_loadable;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk;
    logic          rst;
    logic          fetch_en;
    logic [31:0]   fetch_pc;
    logic          stall;
    logic          flush;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          fetch_fault;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          loading;
`ifdef IMEM_PARITY_EN
    logic          parity_err;
`endif

    imem_sync_loadable #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_pc    (fetch_pc),
        .stall       (stall),
        .flush       (flush),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .loading     (loading)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle/run, 1=taking beats, 2=one settle cycle.
    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    int          m_phase = 0;
    int          m_ptr   = 0;
    logic [31:0] e_instr = NOP;
    logic [31:0] e_pc    = 0;
    bit          e_valid = 0;
    bit          e_fault = 0;
    bit          e_perr  = 0;

    always @(posedge clk or posedge rst) begin : model
        int nphase;
        bit acc;
        int idx;
        if (rst) begin
            m_phase = 0; m_ptr = 0;
            e_instr = NOP; e_pc = 0; e_valid = 0; e_fault = 0; e_perr = 0;
        end else begin
            acc    = (m_phase == 1) && load_valid;
            nphase = m_phase;
            if (m_phase == 0 && load_start) begin
                nphase = 1;
                m_ptr  = int'(load_base);
            end else if (m_phase == 1 && acc && load_last) begin
                nphase = 2;
            end else if (m_phase == 2) begin
                nphase = 0;
            end
            if (flush || nphase != 0) begin
                e_instr = NOP; e_valid = 0; e_fault = 0; e_perr = 0;
            end else if (stall) begin
                e_valid = e_valid;
            end else if (m_phase == 0 && fetch_en) begin
                e_pc = fetch_pc; e_valid = 1; e_fault = 0; e_perr = 0;
                if ((fetch_pc % 4) != 0 || (fetch_pc / 4) >= DEPTH) begin
                    e_instr = NOP; e_fault = 1;
                end else begin
                    idx = int'(fetch_pc / 4);
                    if (m_bad[idx]) begin
                        e_instr = NOP; e_perr = 1;
                    end else begin
                        e_instr = m_mem[idx];
                    end
                end
            end else begin
                e_instr = NOP; e_valid = 0; e_fault = 0; e_perr = 0;
            end
            if (acc) begin
                m_mem[m_ptr] = load_data;
                m_bad[m_ptr] = 0;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            m_phase = nphase;
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("cmp_instr",   instr,              e_instr);
            chk("cmp_valid",   32'(instr_valid),   32'(e_valid));
            chk("cmp_fault",   32'(fetch_fault),   32'(e_fault));
            chk("cmp_ready",   32'(load_ready),    32'(m_phase == 1));
            chk("cmp_loading", 32'(loading),       32'(m_phase != 0));
            if (e_valid) chk("cmp_pc", instr_pc, e_pc);
`ifdef IMEM_PARITY_EN
            chk("cmp_perr",    32'(parity_err),    32'(e_perr));
`endif
        end
    end

    task automatic idle(input int n);
        fetch_en = 0; stall = 0; flush = 0;
        load_start = 0; load_valid = 0; load_last = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pc);
        fetch_en = 1; fetch_pc = pc;
        @(negedge clk);
        fetch_en = 0;
    endtask

    task automatic load_start_at(input logic [AW-1:0] base);
        load_start = 1; load_base = base;
        @(negedge clk);
        load_start = 0;
    endtask

    task automatic beat(input logic [31:0] d, input bit v, input bit last);
        load_valid = v; load_data = d; load_last = last;
        @(negedge clk);
        load_valid = 0; load_last = 0;
    endtask

    initial begin
        rst = 1; fetch_en = 0; fetch_pc = 0; stall = 0; flush = 0;
        load_start = 0; load_base = '0; load_valid = 0; load_data = 0; load_last = 0;
        repeat (2) @(negedge clk);
        chk("rst_instr",   instr,              NOP);
        chk("rst_pc",      instr_pc,           32'h0);
        chk("rst_valid",   32'(instr_valid),   32'h0);
        chk("rst_fault",   32'(fetch_fault),   32'h0);
        chk("rst_ready",   32'(load_ready),    32'h0);
        chk("rst_loading", 32'(loading),       32'h0);
        rst = 0;
        run_cmp = 1;
        idle(1);

        // 1: three-word load then fetch back
        load_start_at('0);
        chk("t1_ready_in_load", 32'(load_ready), 32'h1);
        beat(32'h00500093, 1, 0);
        beat(32'h00A00113, 1, 0);
        beat(32'h002081B3, 1, 1);
        chk("t1_drain_loading", 32'(loading), 32'h1);
        @(negedge clk);
        chk("t1_run_loading", 32'(loading), 32'h0);
        fetch(32'h0); chk("t1_w0", instr, 32'h00500093);
        fetch(32'h4); chk("t1_w1", instr, 32'h00A00113);
        fetch(32'h8); chk("t1_w2", instr, 32'h002081B3);
        chk("t1_valid", 32'(instr_valid), 32'h1);
        idle(1);

        // 2: stall hold, then flush during stall
        fetch_en = 1; fetch_pc = 32'h4;
        @(negedge clk);
        fetch_pc = 32'h8; stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_instr", instr,    32'h00A00113);
            chk("t2_hold_pc",    instr_pc, 32'h4);
        end
        flush = 1;
        @(negedge clk);
        chk("t2_flush_instr", instr,              NOP);
        chk("t2_flush_valid", 32'(instr_valid),   32'h0);
        idle(1);

        // 3: faults and wrapping load
        fetch(32'h6);
        chk("t3_mis_fault", 32'(fetch_fault), 32'h1);
        chk("t3_mis_instr", instr,            NOP);
        chk("t3_mis_valid", 32'(instr_valid), 32'h1);
        fetch(32'(4 * DEPTH));
        chk("t3_oor_fault", 32'(fetch_fault), 32'h1);
        idle(1);
        load_start_at(AW'(DEPTH - 1));
        beat(32'hAAAA0001, 1, 0);
        beat(32'hBBBB0002, 1, 1);
        idle(1);
        fetch(32'(4 * (DEPTH - 1))); chk("t3_top", instr, 32'hAAAA0001);
        fetch(32'h0);                chk("t3_wrap", instr, 32'hBBBB0002);
        idle(1);

        // 4: asynchronous reset in the middle of a load
        load_start_at('0);
        beat(32'hC0C0C001, 1, 0);
        load_valid = 1; load_data = 32'hC0C0C002;
        #2 rst = 1;
        #1;
        chk("t4_rst_loading", 32'(loading),     32'h0);
        chk("t4_rst_ready",   32'(load_ready),  32'h0);
        chk("t4_rst_instr",   instr,            NOP);
        chk("t4_rst_valid",   32'(instr_valid), 32'h0);
        load_valid = 0;
        @(negedge clk);
        rst = 0;
        idle(1);
        fetch(32'h0); chk("t4_kept_beat1", instr, 32'hC0C0C001);
        fetch(32'h4); chk("t4_no_beat2",   instr, 32'h00A00113);
        idle(1);

        // 5: gapped valid, restart attempt ignored while loading
        load_start_at(AW'(8));
        beat(32'hD0000001, 1, 0);
        load_start = 1; load_base = AW'(3);
        beat(32'hDEADDEAD, 0, 0);
        load_start = 0;
        chk("t5_ready_gap", 32'(load_ready), 32'h1);
        beat(32'hD0000002, 1, 0);
        beat(32'hDEADBEEF, 0, 1);
        beat(32'hD0000003, 1, 1);
        idle(1);
        fetch(32'd32); chk("t5_b1", instr, 32'hD0000001);
        fetch(32'd36); chk("t5_b2", instr, 32'hD0000002);
        fetch(32'd40); chk("t5_b3", instr, 32'hD0000003);
        idle(1);

`ifdef IMEM_PARITY_EN
        // 6: corrupt stored word 2 and read it back
        dut.mem[2] = dut.mem[2] ^ 33'h4;
        m_bad[2] = 1;
        fetch(32'h8);
        chk("t6_perr",  32'(parity_err),  32'h1);
        chk("t6_instr", instr,            NOP);
        chk("t6_valid", 32'(instr_valid), 32'h1);
        idle(1);
`else
        fetch(32'h8); chk("t6_plain", instr, 32'h002081B3);
        idle(1);
`endif

        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
